// File: rtl/instruction_queue_pkg.sv
// instruction_queue_pkg: RV32I opcode, queue entry type and immediate folding shared by the instruction queue
package instruction_queue_pkg;
  typedef logic [31:0] rv32i_word;
  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode_t;
  typedef struct packed {
    rv32i_opcode_t opcode;
    logic [2:0]    funct3;
    logic [6:0]    funct7;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic [4:0]    rd;
    rv32i_word     imm;
    rv32i_word     pc;
  } iq_entry_t;
  function automatic rv32i_word select_imm(input rv32i_opcode_t opcode, input rv32i_word i, input rv32i_word s,
                                           input rv32i_word b, input rv32i_word u, input rv32i_word j);
    return (opcode == op_lui || opcode == op_auipc) ? u :
           (opcode == op_jal)   ? j :
           (opcode == op_br)    ? b :
           (opcode == op_store) ? s : i;
  endfunction
endpackage

// File: rtl/instruction_queue_storage.sv
// iq_storage: unreset entry array with one write port and one asynchronous read port
module iq_storage
  import instruction_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  iq_entry_t     wdata,
  input  logic [AW-1:0] raddr,
  output iq_entry_t     rdata
);
  iq_entry_t mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/instruction_queue.sv
// instruction_queue: circular FIFO of decoded instructions between the fetcher and dispatch, with flush
module instruction_queue
  import instruction_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH) + 1,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  output logic             rdy_o,
  input  rv32i_opcode_t    opcode_i,
  input  logic [2:0]       funct3_i,
  input  logic [6:0]       funct7_i,
  input  logic [4:0]       rs1_i,
  input  logic [4:0]       rs2_i,
  input  logic [4:0]       rd_i,
  input  rv32i_word        i_imm_i,
  input  rv32i_word        s_imm_i,
  input  rv32i_word        b_imm_i,
  input  rv32i_word        u_imm_i,
  input  rv32i_word        j_imm_i,
  input  rv32i_word        pc_i,
  input  logic             flush_i,
  input  logic             deq_i,
  output logic             valid_o,
  output iq_entry_t        entry_o,
  output logic [CNT_W-1:0] count_o
);
  logic [AW-1:0]    head, tail;
  logic [CNT_W-1:0] count;
  logic             enq, deq;
  iq_entry_t        wdata, rdata;
  // rdy_o is gated by rst so it reads 0 throughout reset, not just after the first edge
  assign rdy_o   = rst & (count != CNT_W'(DEPTH));
  assign valid_o = count != '0;
  assign enq     = load_i & rdy_o;
  assign deq     = deq_i & valid_o;
  assign count_o = count;
  assign entry_o = valid_o ? rdata : '0;
  assign wdata = '{
    opcode: opcode_i,
    funct3: funct3_i,
    funct7: funct7_i,
    rs1:    rs1_i,
    rs2:    rs2_i,
    rd:     rd_i,
    imm:    select_imm(opcode_i, i_imm_i, s_imm_i, b_imm_i, u_imm_i, j_imm_i),
    pc:     pc_i
  };
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= tail + 1'b1;
      if (deq) head <= head + 1'b1;
      count <= count + CNT_W'(enq) - CNT_W'(deq);
    end
  iq_storage #(.DEPTH(DEPTH)) u_storage (
    .clk   (clk),
    .we    (enq & ~flush_i),
    .waddr (tail),
    .wdata (wdata),
    .raddr (head),
    .rdata (rdata)
  );
endmodule

// File: tb/tb_instruction_queue.sv
// tb_instruction_queue: scoreboard bench for instruction_queue covering selection, full, wrap, flush and async reset
module tb_instruction_queue;
  import instruction_queue_pkg::*;
  localparam int DEPTH = 8;
  logic clk = 0, rst = 0, load_i = 0, flush_i = 0, deq_i = 0;
  logic rdy_o, valid_o;
  rv32i_opcode_t op = op_imm;
  logic [2:0] f3 = 0;
  logic [6:0] f7 = 0;
  logic [4:0] r1 = 0, r2 = 0, rd = 0;
  rv32i_word ii = 0, si = 0, bi = 0, ui = 0, ji = 0, pc = 0;
  iq_entry_t entry_o;
  logic [3:0] count_o;
  iq_entry_t sb[$];
  int total = 0, bad = 0;

  instruction_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .load_i(load_i), .rdy_o(rdy_o), .opcode_i(op), .funct3_i(f3), .funct7_i(f7),
    .rs1_i(r1), .rs2_i(r2), .rd_i(rd), .i_imm_i(ii), .s_imm_i(si), .b_imm_i(bi), .u_imm_i(ui), .j_imm_i(ji),
    .pc_i(pc), .flush_i(flush_i), .deq_i(deq_i), .valid_o(valid_o), .entry_o(entry_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  function automatic rv32i_word exp_imm();
    case (op)
      op_lui, op_auipc: return ui;
      op_jal:           return ji;
      op_br:            return bi;
      op_store:         return si;
      default:          return ii;
    endcase
  endfunction

  task automatic set_instr(input rv32i_opcode_t o, input rv32i_word imm, input rv32i_word p);
    op = o; pc = p;
    f3 = 3'($urandom); f7 = 7'($urandom); r1 = 5'($urandom); r2 = 5'($urandom); rd = 5'($urandom);
    ii = $urandom; si = $urandom; bi = $urandom; ui = $urandom; ji = $urandom;
    case (o)
      op_lui, op_auipc: ui = imm;
      op_jal:           ji = imm;
      op_br:            bi = imm;
      op_store:         si = imm;
      default:          ii = imm;
    endcase
  endtask

  task automatic step(input logic ld, input logic dq, input logic fl);
    iq_entry_t e;
    bit enq_ok, deq_ok;
    load_i = ld; deq_i = dq; flush_i = fl;
    total++;
    if (rdy_o !== (sb.size() != DEPTH)) begin bad++; $display("FAIL rdy got=%b want=%b", rdy_o, sb.size() != DEPTH); end
    total++;
    if (valid_o !== (sb.size() != 0)) begin bad++; $display("FAIL valid got=%b want=%b", valid_o, sb.size() != 0); end
    total++;
    if (count_o !== 4'(sb.size())) begin bad++; $display("FAIL count got=%0d want=%0d", count_o, sb.size()); end
    if (sb.size() == 0) begin
      total++;
      if (entry_o !== '0) begin bad++; $display("FAIL empty_entry got=%h want=0", entry_o); end
    end else if (dq && !fl) begin
      total++;
      if (entry_o !== sb[0]) begin bad++; $display("FAIL entry got=%h want=%h (pc got=%h want=%h)", entry_o, sb[0], entry_o.pc, sb[0].pc); end
    end
    enq_ok = ld && sb.size() != DEPTH;
    deq_ok = dq && sb.size() != 0;
    e = '{opcode: op, funct3: f3, funct7: f7, rs1: r1, rs2: r2, rd: rd, imm: exp_imm(), pc: pc};
    if (fl) sb.delete();
    else begin
      if (deq_ok) void'(sb.pop_front());
      if (enq_ok) sb.push_back(e);
    end
    @(posedge clk); #1;
    load_i = 0; deq_i = 0; flush_i = 0;
  endtask

  task automatic drain();
    while (sb.size() != 0) step(0, 1, 0);
    step(0, 0, 0);
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (valid_o !== 0 || rdy_o !== 0 || count_o !== 0 || entry_o !== '0) begin
      bad++; $display("FAIL reset_outputs got valid=%b rdy=%b count=%0d entry=%h want 0/0/0/0", valid_o, rdy_o, count_o, entry_o);
    end
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
    step(0, 0, 0);
  endtask

  task automatic test_basic();
    set_instr(op_lui, 32'h12345000, 32'h60);
    step(1, 0, 0);
    total++;
    if (entry_o.imm !== 32'h12345000 || entry_o.pc !== 32'h60) begin
      bad++; $display("FAIL basic_entry got imm=%h pc=%h want imm=12345000 pc=60", entry_o.imm, entry_o.pc);
    end
    step(0, 1, 0);
    step(0, 0, 0);
  endtask

  task automatic test_imm_select();
    set_instr(op_br, 32'hFFFFFFF8, 32'h100); step(1, 0, 0);
    set_instr(op_store, 32'h10, 32'h104);    step(1, 0, 0);
    set_instr(op_jal, 32'h800, 32'h108);     step(1, 0, 0);
    set_instr(op_load, 32'h4, 32'h10C);      step(1, 0, 0);
    set_instr(op_auipc, 32'hABC00000, 32'h110); step(1, 0, 0);
    set_instr(op_reg, 32'h5A5A5A5A, 32'h114);   step(1, 0, 0);
    drain();
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) begin
      set_instr(op_imm, 32'(i), 32'(i * 4));
      step(1, 0, 0);
    end
    set_instr(op_imm, 32'h77, 32'h20);
    step(1, 1, 0);
    total++;
    if (count_o !== 4'd7 || rdy_o !== 1) begin bad++; $display("FAIL full_stall got count=%0d rdy=%b want 7/1", count_o, rdy_o); end
    step(1, 0, 0);
    drain();
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 3; i++) begin set_instr(op_auipc, 32'(i) << 12, 32'(i * 4)); step(1, 0, 0); end
    for (int i = 3; i < 20; i++) begin
      set_instr(op_auipc, 32'(i) << 12, 32'(i * 4));
      step(1, 1, 0);
      total++;
      if (count_o !== 4'd3) begin bad++; $display("FAIL wrap_count got=%0d want=3", count_o); end
    end
    drain();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin set_instr(op_jal, 32'(i), 32'h200 + 32'(i * 4)); step(1, 0, 0); end
    set_instr(op_jal, 32'h999, 32'h300);
    step(1, 1, 1);
    total++;
    if (count_o !== 0 || valid_o !== 0 || rdy_o !== 1) begin
      bad++; $display("FAIL flush got count=%0d valid=%b rdy=%b want 0/0/1", count_o, valid_o, rdy_o);
    end
    set_instr(op_store, 32'h44, 32'h400);
    step(1, 0, 0);
    total++;
    if (count_o !== 1 || entry_o.pc !== 32'h400) begin bad++; $display("FAIL flush_after got count=%0d pc=%h want 1/400", count_o, entry_o.pc); end
    drain();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) begin set_instr(op_imm, 32'(i), 32'h500 + 32'(i * 4)); step(1, 0, 0); end
    #2;
    rst = 0; load_i = 1;
    #1;
    total++;
    if (valid_o !== 0 || rdy_o !== 0 || count_o !== 0 || entry_o !== '0) begin
      bad++; $display("FAIL async_reset got valid=%b rdy=%b count=%0d want 0/0/0", valid_o, rdy_o, count_o);
    end
    sb.delete();
    @(posedge clk); #1;
    @(negedge clk); rst = 1; load_i = 0;
    #1;
    total++;
    if (rdy_o !== 1 || count_o !== 0 || valid_o !== 0) begin
      bad++; $display("FAIL reset_release got rdy=%b count=%0d valid=%b want 1/0/0", rdy_o, count_o, valid_o);
    end
    @(posedge clk); #1;
    set_instr(op_lui, 32'h7000, 32'h600);
    step(1, 0, 0);
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_imm_select();
    test_full();
    test_wrap();
    test_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
